fifo_array_skew_reader: RTL and testbench

- Read-side controller for the input FIFO array that feeds the systolic PE grid.
- Drains ARRAY_SIZE FIFOs in a diagonal (skewed) schedule: lane i starts i cycles after lane 0.
- Each lane delivers exactly `length` words; inactive lanes are zero-filled.
- Sits between the FIFO array's r_en/out_bus/empty and the first PE row/column.

---
 rtl/fifo_array_skew_reader_pkg.sv | 20 ++
 rtl/fifo_array_skew_reader_skew_lane.sv | 48 ++++
 rtl/fifo_array_skew_reader.sv | 127 ++++++++++++
 tb/tb_fifo_array_skew_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_array_skew_reader_pkg.sv
// Shared definitions for the skewed FIFO-array reader: FSM encodings and default sizes.
// The encodings match those used by the FIFO array and the PE grid.
package fifo_array_skew_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_SIZE  = 16;
  localparam int DEF_ARRAY_SIZE = 9;
  localparam int DEF_LEN_W      = 12;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_array_skew_reader_skew_lane.sv
// One lane of the skewed reader: active-window compare, read-valid register
// and zero-fill of the word handed to the PE edge.
module skew_lane #(
  parameter int DATA_SIZE = 16,
  parameter int T_W       = 16,
  parameter int LANE      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [T_W-1:0]       i_t,
  input  logic [T_W-1:0]       i_len,
  input  logic                 i_step_en,
  input  logic [DATA_SIZE-1:0] i_fifo_word,
  output logic                 o_active,
  output logic                 o_r_en,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_word
);

  localparam logic [T_W-1:0] LANE_IDX = T_W'(LANE);

  logic           w_lo_ok;
  logic [T_W-1:0] w_end;
  logic           r_valid;

  // Lane 0 has no lower bound, so the compare is elided there.
  if (LANE == 0) begin : g_lo_first
    assign w_lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign w_lo_ok = (i_t >= LANE_IDX);
  end

  assign w_end    = LANE_IDX + i_len;
  assign o_active = w_lo_ok && (i_t < w_end);
  assign o_r_en   = o_active && i_step_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= o_r_en;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_valid ? i_fifo_word : '0;

endmodule

// File: rtl/fifo_array_skew_reader.sv
// Drains ARRAY_SIZE FIFOs on a diagonal schedule (lane i lags lane 0 by i cycles).
// Define FIFO_SKEW_READER_STATS_EN to add the 32-bit stall_cycles counter output.
module fifo_array_skew_reader
  import fifo_array_skew_reader_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LEN_W-1:0]                length,
  input  logic [ARRAY_SIZE-1:0]           empty,
  input  logic [DATA_SIZE*ARRAY_SIZE-1:0] fifo_data,
  output logic [ARRAY_SIZE-1:0]           r_en,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0] out_data,
  output logic [ARRAY_SIZE-1:0]           out_valid,
  output logic                            busy,
  output logic                            stall,
`ifdef FIFO_SKEW_READER_STATS_EN
  output logic [31:0]                     stall_cycles,
`endif
  output logic                            done
);

  localparam int T_W = LEN_W + 4;

  state_t                r_state, w_state_next;
  logic [T_W-1:0]        r_t, w_t_next;
  logic [T_W-1:0]        r_len, w_len_next;
  logic [T_W-1:0]        w_t_last;
  logic [ARRAY_SIZE-1:0] w_active;
  logic                  w_run;
  logic                  w_stall;
  logic                  w_step_en;
  logic                  w_accept;

  assign w_run     = (r_state == ST_RUN);
  // Any active lane running dry freezes the whole diagonal so the skew survives.
  assign w_stall   = w_run && |(w_active & empty);
  assign w_step_en = w_run && !w_stall;
  assign w_accept  = (r_state == ST_IDLE) && start;
  // Wraps harmlessly to L-1 when ARRAY_SIZE is 1.
  assign w_t_last  = r_len + T_W'(ARRAY_SIZE - 2);

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    skew_lane #(
      .DATA_SIZE(DATA_SIZE),
      .T_W      (T_W),
      .LANE     (gi)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_t        (r_t),
      .i_len      (r_len),
      .i_step_en  (w_step_en),
      .i_fifo_word(fifo_data[gi*DATA_SIZE +: DATA_SIZE]),
      .o_active   (w_active[gi]),
      .o_r_en     (r_en[gi]),
      .o_valid    (out_valid[gi]),
      .o_word     (out_data[gi*DATA_SIZE +: DATA_SIZE])
    );
  end

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    w_len_next   = r_len;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_len_next   = {4'b0000, length};
          w_t_next     = '0;
          w_state_next = (length != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (!w_stall) begin
          w_t_next = r_t + 1'b1;
          if (r_t == w_t_last) begin
            w_state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      r_t     <= w_t_next;
      r_len   <= w_len_next;
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_DONE);
  assign stall = w_stall;

`ifdef FIFO_SKEW_READER_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_accept) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= sat_inc32(r_stall_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_fifo_array_skew_reader.sv
// Directed bench for fifo_array_skew_reader (3 lanes): FIFO model, scoreboard
// queues per lane and a negedge monitor that pops expected words.
module tb_fifo_array_skew_reader;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int LW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [LW-1:0]   length = '0;
  logic [N-1:0]    empty;
  logic [DW*N-1:0] fifo_data;
  logic [N-1:0]    r_en;
  logic [DW*N-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic            busy, stall, done;
`ifdef FIFO_SKEW_READER_STATS_EN
  logic [31:0]     stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] force_empty = '0;
  int           fill   [N] = '{0, 0, 0};
  int           rd_ptr [N] = '{0, 0, 0};
  logic [DW-1:0] fifo_out [N] = '{16'hA5A1, 16'hA5A2, 16'hA5A3};
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [DW-1:0] exp_q2 [$];

  always #5 clk = ~clk;

  fifo_array_skew_reader #(.DATA_SIZE(DW), .ARRAY_SIZE(N), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .length   (length),
    .empty    (empty),
    .fifo_data(fifo_data),
    .r_en     (r_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .stall    (stall),
`ifdef FIFO_SKEW_READER_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .done     (done)
  );

  function automatic logic [DW-1:0] word(input int lane, input int k);
    return {4'(lane + 1), 12'(k)};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // FIFO array model: data appears one cycle after r_en.
  always_comb begin
    empty = '0;
    for (int i = 0; i < N; i++) empty[i] = (rd_ptr[i] >= fill[i]) || force_empty[i];
  end
  assign fifo_data = {fifo_out[2], fifo_out[1], fifo_out[0]};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (r_en[i]) begin
        fifo_out[i] <= word(i, rd_ptr[i]);
        rd_ptr[i]   <= rd_ptr[i] + 1;
      end
    end
  end

  function automatic int qsize(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qfront(input int i);
    case (i)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic void qpop(input int i);
    case (i)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endfunction

  function automatic void qpush(input int i, input logic [DW-1:0] w);
    case (i)
      0: exp_q0.push_back(w);
      1: exp_q1.push_back(w);
      default: exp_q2.push_back(w);
    endcase
  endfunction

  // Monitor: pop and compare whenever a lane presents valid data.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("no_read_when_empty", r_en & empty, '0);
      for (int i = 0; i < N; i++) begin
        if (out_valid[i]) begin
          if (qsize(i) == 0) begin
            chk($sformatf("lane%0d unexpected valid", i), 1, 0);
          end else begin
            chk($sformatf("lane%0d data", i), out_data[i*DW +: DW], qfront(i));
            qpop(i);
          end
        end else begin
          chk($sformatf("lane%0d zero-fill", i), out_data[i*DW +: DW], '0);
        end
      end
    end
  end

  // One pass, checked cycle by cycle against hand-computed tables.
  task automatic run_pass(input string nm, input int len, input logic [35:0] ren_tab,
                          input logic [11:0] stall_tab, input int done_cyc,
                          input int fe_from, input int fe_to, input int restart_cyc);
    int base [N];
    for (int i = 0; i < N; i++) begin
      base[i] = rd_ptr[i];
      for (int k = 0; k < len; k++) qpush(i, word(i, fill[i] + k));
      fill[i] += len;
    end
    for (int c = 0; c <= done_cyc + 1; c++) begin
      @(posedge clk); #1;
      start       = (c == 0) || (c == restart_cyc);
      length      = (c == 0) ? LW'(len) : 12'd7;
      force_empty = (c >= fe_from && c <= fe_to) ? 3'b010 : 3'b000;
      @(negedge clk);
      chk($sformatf("%s r_en c%0d", nm, c), r_en, ren_tab[c*3 +: 3]);
      chk($sformatf("%s stall c%0d", nm, c), stall, stall_tab[c]);
      chk($sformatf("%s done c%0d", nm, c), done, (c == done_cyc));
      chk($sformatf("%s busy c%0d", nm, c), busy, (c >= 1 && c <= done_cyc));
      $display("[TB] %s c%0d r_en=%b valid=%b stall=%b busy=%b done=%b", nm, c, r_en, out_valid, stall, busy, done);
    end
    start = 1'b0;
    force_empty = '0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s reads lane%0d", nm, i), rd_ptr[i] - base[i], len);
      chk($sformatf("%s backlog lane%0d", nm, i), qsize(i), fill[i] - rd_ptr[i]);
    end
  endtask

  localparam logic [35:0] TAB1 = {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                  3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
  localparam logic [35:0] TAB2 = {3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b110,
                                  3'b111, 3'b000, 3'b000, 3'b011, 3'b001, 3'b000};

  initial begin
    force_empty = '0;
    #1;
    chk("reset r_en", r_en, '0);
    chk("reset out_valid", out_valid, '0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_pass("basic", 3, TAB1, 12'h000, 7, -1, -1, -1);
`ifdef FIFO_SKEW_READER_STATS_EN
    chk("basic stall_cycles", stall_cycles, 0);
`endif
    run_pass("stall", 3, TAB2, 12'b0000_0001_1000, 9, 3, 4, -1);
`ifdef FIFO_SKEW_READER_STATS_EN
    chk("stall stall_cycles", stall_cycles, 2);
`endif
    run_pass("len0", 0, 36'd0, 12'h000, 1, -1, -1, -1);
    run_pass("restart", 3, TAB1, 12'h000, 7, -1, -1, 2);

    // Abort mid-pass with an asynchronous reset in cycle 3.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) qpush(i, word(i, fill[i] + k));
      fill[i] += 3;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start  = (c == 0);
      length = 12'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort r_en", r_en, '0);
    chk("abort out_valid", out_valid, '0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    $display("[TB] abort r_en=%b valid=%b busy=%b done=%b", r_en, out_valid, busy, done);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Words already read before the abort never reach the PEs; drop them.
    for (int i = 0; i < N; i++) begin
      while (qsize(i) > 0 && qfront(i) != word(i, rd_ptr[i])) qpop(i);
    end
    run_pass("post_reset", 3, TAB1, 12'h000, 7, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
